audio_seq_player: RTL



---
 rtl/audio_seq_player_if.sv | 20 ++
 rtl/audio_seq_player.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/audio_seq_player_if.sv
// Control and output bundle between the game FSM and the tone-sequence player.
// The player takes the slave view; the FSM and amplifier side take the master view.
interface audio_seq_player_if;
  logic       enable;
  logic [2:0] audio_select;
  logic       seq_end;
  logic       pwm_pin;
  logic       amp_pin;
  logic       busy;

  modport master (
    output enable, audio_select,
    input  seq_end, pwm_pin, amp_pin, busy
  );

  modport slave (
    input  enable, audio_select,
    output seq_end, pwm_pin, amp_pin, busy
  );
endinterface

// File: rtl/audio_seq_player.sv
// Plays fixed note sequences from an internal ROM as a square wave on pwm_pin,
// pulsing seq_end once when a sequence completes; enable low aborts playback.
module audio_seq_player #(
  parameter int unsigned TICK_CYC  = 5_000_000,
  parameter int unsigned TONE_UNIT = 10_000
) (
  input  logic               clk,
  input  logic               rst,
  audio_seq_player_if.slave  bus
);

  localparam int unsigned TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    tone_q, tone_d;
  logic [3:0]    dur_q, dur_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [20:0]   half_q, half_d;
  logic          phase_q, phase_d;
  logic          done_seen_q, done_seen_d;
  logic          seq_end_q, seq_end_d;
  logic          pwm_q, pwm_d;
  logic          amp_q, amp_d;
  logic          busy_q, busy_d;

  logic [7:0]    word;
  logic [20:0]   half_cyc;
  logic          tick_wrap;
  logic          note_end;

  function automatic logic [7:0] rom(input logic [2:0] s, input logic [3:0] i);
    logic [7:0] w;
    w = 8'h00;
    case (s)
      3'd1: case (i) 4'd0: w = 8'hC2; 4'd1: w = 8'hE2; 4'd2: w = 8'hF4; default: w = 8'h00; endcase
      3'd2: case (i) 4'd0: w = 8'h84; 4'd1: w = 8'h64; 4'd2: w = 8'h48; default: w = 8'h00; endcase
      3'd3: case (i) 4'd0: w = 8'hA2; 4'd1: w = 8'hC2; 4'd2: w = 8'hE2; 4'd3: w = 8'hF8;
                     default: w = 8'h00; endcase
      3'd4: case (i) 4'd0: w = 8'hC2; 4'd1: w = 8'hF2; default: w = 8'h00; endcase
      3'd5: case (i) 4'd0: w = 8'hA2; 4'd1: w = 8'h01; 4'd2: w = 8'hA2; 4'd3: w = 8'hF4;
                     default: w = 8'h00; endcase
      3'd6: case (i) 4'd0: w = 8'h36; default: w = 8'h00; endcase
      3'd7: w = 8'hF1;
      default: w = 8'h00;
    endcase
    return w;
  endfunction

  assign word      = rom(sel_q, idx_q);
  assign half_cyc  = 21'(TONE_UNIT) * (21'd16 - {17'd0, tone_q});
  assign tick_wrap = (tick_q == TW'(TICK_CYC - 1));
  assign note_end  = tick_wrap && (dur_q == 4'd1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    tone_d  = tone_q;
    dur_d   = dur_q;
    tick_d  = tick_q;
    half_d  = half_q;
    phase_d = phase_q;

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          sel_d   = bus.audio_select;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (word[3:0] == 4'd0) begin
          state_d = DONE;
        end else begin
          tone_d  = word[7:4];
          dur_d   = word[3:0];
          tick_d  = '0;
          half_d  = '0;
          phase_d = 1'b0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (!bus.enable) begin
          phase_d = 1'b0;
          state_d = IDLE;
        end else begin
          tick_d = tick_wrap ? '0 : tick_q + 1'b1;
          if (tick_wrap) dur_d = dur_q - 4'd1;
          if (half_q == half_cyc - 21'd1) begin
            half_d  = '0;
            phase_d = ~phase_q;
          end else begin
            half_d = half_q + 21'd1;
          end
          if (note_end) begin
            phase_d = 1'b0;
            if (idx_q == 4'd15) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = LOAD;
            end
          end
        end
      end
      DONE: begin
        if (!bus.enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the current state, but gated by enable so an
  // abort clears them on the same edge that returns the FSM to IDLE. busy skips
  // the first LOAD so an empty sequence never raises it.
  always_comb begin
    amp_d       = (state_q == PLAY) && bus.enable;
    pwm_d       = amp_d && phase_q && (tone_q != 4'd0);
    busy_d      = bus.enable && ((state_q == PLAY) || ((state_q == LOAD) && (idx_q != 4'd0)));
    done_seen_d = (state_q == DONE);
    seq_end_d   = (state_q == DONE) && !done_seen_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      idx_q       <= '0;
      tone_q      <= '0;
      dur_q       <= '0;
      tick_q      <= '0;
      half_q      <= '0;
      phase_q     <= 1'b0;
      done_seen_q <= 1'b0;
      seq_end_q   <= 1'b0;
      pwm_q       <= 1'b0;
      amp_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      tone_q      <= tone_d;
      dur_q       <= dur_d;
      tick_q      <= tick_d;
      half_q      <= half_d;
      phase_q     <= phase_d;
      done_seen_q <= done_seen_d;
      seq_end_q   <= seq_end_d;
      pwm_q       <= pwm_d;
      amp_q       <= amp_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.seq_end = seq_end_q;
  assign bus.pwm_pin = pwm_q;
  assign bus.amp_pin = amp_q;
  assign bus.busy    = busy_q;

endmodule
